serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Multi-cycle adder sequencer for the 32-bit ALU area-optimised path.
//   Instantiates a single 2-bit FullAdder2 slice and reuses it WIDTH/2 times.
//   Operands shift through the slice 2 bits per clock, with a registered carry.
//   Start/busy/done handshake toward the ALU control FSM.
// PARAMETERS
//   WIDTH   32   operand/result width; must be even and >= 4
//   CNT_W   5    counter width; must satisfy 2**CNT_W >= WIDTH/2
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; sampled only in IDLE or DONE
//   in1     in   WIDTH  operand A; sampled on the accepted start edge
//   in2     in   WIDTH  operand B; sampled on the accepted start edge
//   cIn     in   1      carry-in; sampled on the accepted start edge
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse; result valid from this cycle on
//   sum     out  WIDTH  registered result; holds until the next completion
//   cOut    out  1      registered final carry; holds with sum
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, sum=0, cOut=0.
//     Internal shift registers, carry and counter are also cleared.
//   FSM states:
//     IDLE -start-> RUN
//     RUN  -(cnt==WIDTH/2-1)-> DONE
//     DONE -start-> RUN; otherwise DONE -> IDLE
//   Accept edge (E0): latch opA<=in1, opB<=in2, carry<=cIn, cnt<=0.
//   RUN edge (E1..E16 for WIDTH=32):
//     - slice inputs = opA[1:0], opB[1:0], carry
//     - acc <= {slice sum, acc[WIDTH-1:2]}
//     - opA, opB shift right by 2
//     - carry <= slice cOut; cnt++
//   Final RUN edge: sum <= assembled acc; cOut <= slice cOut.
//   Latency: done is high exactly WIDTH/2 clocks after the accept edge.
//     For WIDTH=32 that is 16 clocks; busy is high for 16 cycles.
//   start while busy: ignored; no queueing and no effect on the current op.
//   in1/in2/cIn changes during RUN: ignored, because operands are latched.
//   start in the DONE cycle: accepted back-to-back.
//     done=1 and busy=0 in that cycle; busy rises on the next cycle.
//   Arithmetic is modulo 2**WIDTH; cOut is the true carry out of bit WIDTH-1.
//   Reset mid-RUN: the operation is aborted, sum/cOut return to 0, no done pulse.
// CONFIGURATION
//   SERIAL_ADD_SUB_EN defined:
//     - extra input port sub (1 bit), sampled on the accept edge.
//     - sub=1: opB latched as ~in2, carry latched as 1; cIn is ignored.
//       Result is in1-in2 and cOut=1 means no borrow.
//     - sub=0: plain add.
//   SERIAL_ADD_SUB_EN undefined:
//     - no sub port; add only.
// TESTING (WIDTH=32)
//   1) in1=0xFFFFFFFF, in2=1, cIn=0, start 1 cycle
//      -> 16 clocks later done=1, sum=0, cOut=1.
//   2) in1=0x12345678, in2=0x11111111, cIn=1
//      -> sum=0x2345678A, cOut=0; busy high for exactly 16 cycles.
//   3) start pulsed during RUN with new operands
//      -> first result unchanged; no second op launched.
//   4) start held high through DONE
//      -> back-to-back op; second done exactly 16 clocks after the first.
//   5) assert rst at RUN cycle 7
//      -> busy=0, sum=0, cOut=0 immediately; no done pulse; next start works.
//   6) SERIAL_ADD_SUB_EN: sub=1, in1=5, in2=7
//      -> sum=0xFFFFFFFE, cOut=0. With in1=7, in2=5: sum=2, cOut=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: one 2-bit slice reused WIDTH/2 times, start/busy/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds the sub port).

module full_adder2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {2'b00, ci};
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cIn,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] op_b_in;
  logic             carry_in;
  logic [1:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] next_acc;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as in1 + ~in2 + 1; cOut=1 then means no borrow.
  assign op_b_in  = sub ? ~in2 : in2;
  assign carry_in = sub ? 1'b1 : cIn;
`else
  assign op_b_in  = in2;
  assign carry_in = cIn;
`endif

  full_adder2 u_slice (
    .a  (op_a[1:0]),
    .b  (op_b[1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each slice result enters at the top, so after WIDTH/2 steps bit 0 sits at acc[0].
  assign next_acc = {slice_s, acc[WIDTH-1:2]};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cOut  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= in1;
            op_b  <= op_b_in;
            carry <= carry_in;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= next_acc;
          op_a  <= op_a >> 2;
          op_b  <= op_b >> 2;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= next_acc;
            cOut  <= slice_co;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=32).
// Define SERIAL_ADD_SUB_EN for both RTL and bench to exercise subtract mode.

module tb_serial_add_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic [WIDTH-1:0] in2 = '0;
  logic             cIn = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cOut;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .cIn   (cIn),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cOut  (cOut)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    @(negedge clk);
    in1 = a; in2 = b; cIn = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the first falling edge after the accept edge; returns with done high.
  task automatic wait_done(input string name, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d clocks, expected %0d", name, cycles, LAT);
    end
  endtask

  task automatic check_result(input string name, input logic [WIDTH-1:0] exp_sum, input logic exp_c);
    checks++;
    if (sum !== exp_sum || cOut !== exp_c || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: sum=%h cOut=%b done=%b busy=%b, expected sum=%h cOut=%b done=1 busy=0",
               name, sum, cOut, done, busy, exp_sum, exp_c);
    end
  endtask

  task automatic run_add(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic [WIDTH-1:0] exp_sum, input logic exp_c);
    int cyc, bcyc;
    launch(a, b, ci);
    wait_done(name, cyc, bcyc);
    check_result(name, exp_sum, exp_c);
    checks++;
    if (bcyc != LAT) begin
      errors++;
      $display("FAIL %s busy width: got %0d, expected %0d", name, bcyc, LAT);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse: done=%b busy=%b one cycle later, expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cOut !== 1'b0) begin
      errors++;
      $display("FAIL reset state: busy=%b done=%b sum=%h cOut=%b, expected all 0", busy, done, sum, cOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_add("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
    run_add("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);
    run_add("zero_cin", 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
    run_add("full_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_add("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int cyc, bcyc;
    bit second;
    launch(32'h1, 32'h2, 1'b0);
    repeat (4) @(negedge clk);
    in1 = 32'hDEAD_BEEF; in2 = 32'h1234_0000; cIn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_result("busy_start", 32'h3, 1'b0);
    second = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done) second = 1'b1;
    end
    checks++;
    if (second) begin
      errors++;
      $display("FAIL busy_start queued: a second op launched, expected none");
    end
    bcyc = 0;
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    @(negedge clk);
    in1 = 32'h0000_0010; in2 = 32'h0000_0020; cIn = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first", cyc, bcyc);
    check_result("b2b_first", 32'h30, 1'b0);
    // Start is still high in the DONE cycle: the next edge accepts the new operands.
    in1 = 32'h8000_0000; in2 = 32'h8000_0001; cIn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_done("b2b_second", cyc, bcyc);
    check_result("b2b_second", 32'h2, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cOut !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset outputs: busy=%b done=%b sum=%h cOut=%b, expected all 0", busy, done, sum, cOut);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset aborted: activity after reset, expected none");
    end
    run_add("after_reset", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    run_add("sub_borrow", 32'h5, 32'h7, 1'b0, 32'hFFFF_FFFE, 1'b0);
    run_add("sub_plain", 32'h7, 32'h5, 1'b0, 32'h2, 1'b1);
    run_add("sub_cin_ignored", 32'h7, 32'h5, 1'b1, 32'h2, 1'b1);
    sub = 1'b0;
    run_add("sub_off", 32'h7, 32'h5, 1'b0, 32'hC, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
